inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fetch.sv | 122 ++++++++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-path definitions: bus widths, reset/enable polarities and helpers.
package inst_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned BYTE_W      = 8;

    localparam logic [INST_W-1:0] ZERO_WORD    = '0;
    localparam logic              RST_ENABLE   = 1'b1;
    localparam logic              TRUE_V       = 1'b1;
    localparam logic              FALSE_V      = 1'b0;
    localparam logic              WRITE_ENABLE = 1'b1;

    // Force a fetch address onto a word boundary.
    function automatic logic [INST_ADDR_W-1:0] align_word(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: icache lookup, byte-serial refill from memory, cache commit.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_taken_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    input  logic [INST_W-1:0]      icache_inst_i,
    output logic [INST_ADDR_W-1:0] icache_pc_o,
    output logic                   icache_pc_valid_o,
    output logic                   icache_we_o,
    output logic [INST_W-1:0]      icache_inst_o,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic [BYTE_W-1:0]      mem_data_i,
    input  logic                   mem_ack_i,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o,
    output logic                   if_valid_o
);

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                 state;
    logic [INST_ADDR_W-1:0] pc;
    logic [1:0]             byte_cnt;
    logic [INST_W-1:0]      buffer;

    // Cache/memory handshake outputs, decoded from state and gated off during reset.
    always_comb begin
        icache_pc_o       = pc;
        icache_pc_valid_o = FALSE_V;
        icache_we_o       = ~WRITE_ENABLE;
        icache_inst_o     = ZERO_WORD;
        mem_req_o         = FALSE_V;
        mem_addr_o        = '0;
        if (rst != RST_ENABLE) begin
            case (state)
                LOOKUP: icache_pc_valid_o = TRUE_V;
                FILL: begin
                    mem_req_o  = TRUE_V;
                    mem_addr_o = pc + INST_ADDR_W'(byte_cnt);
                end
                COMMIT: begin
                    icache_pc_valid_o = TRUE_V;
                    icache_we_o       = WRITE_ENABLE;
                    icache_inst_o     = buffer;
                end
                default: ;
            endcase
        end
    end

    // Fetch FSM plus PC, refill buffer and delivered-instruction registers.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state      <= LOOKUP;
            pc         <= RESET_PC;
            byte_cnt   <= 2'd0;
            buffer     <= ZERO_WORD;
            if_valid_o <= FALSE_V;
            if_pc_o    <= '0;
            if_inst_o  <= ZERO_WORD;
        end else if (branch_taken_i) begin
            // Redirect wins over everything, including an ack arriving this cycle.
            state      <= LOOKUP;
            pc         <= align_word(branch_target_i);
            byte_cnt   <= 2'd0;
            buffer     <= ZERO_WORD;
            if_valid_o <= FALSE_V;
        end else begin
            case (state)
                LOOKUP: begin
                    if (icache_inst_i != ZERO_WORD) begin
                        if (!stall_i) begin
                            if_valid_o <= TRUE_V;
                            if_pc_o    <= pc;
                            if_inst_o  <= icache_inst_i;
                            pc         <= pc + INST_ADDR_W'(4);
                        end
                    end else begin
                        // A miss starts the refill even while downstream is stalled.
                        state    <= FILL;
                        byte_cnt <= 2'd0;
                        buffer   <= ZERO_WORD;
                        if (!stall_i) begin
                            if_valid_o <= FALSE_V;
                        end
                    end
                end
                FILL: begin
                    if (!stall_i) begin
                        if_valid_o <= FALSE_V;
                    end
                    if (mem_ack_i) begin
                        buffer[{byte_cnt, 3'b000} +: BYTE_W] <= mem_data_i;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    if (!stall_i) begin
                        if_valid_o <= FALSE_V;
                    end
                    state <= LOOKUP;
                end
                default: state <= LOOKUP;
            endcase
        end
    end

endmodule
